// File: rtl/cutelock_arb_pkg.sv
// Shared types and helpers for the key-locked queue arbiter and its key schedule.
package cutelock_arb_pkg;

  typedef enum logic {
    PH_SAMPLE = 1'b0,
    PH_SERVE  = 1'b1
  } phase_e;

  localparam int SCHED_MAX_W = 256;
  localparam int KEY_MAX_W   = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Occupancy counter must represent 0..n inclusive.
  function automatic int occ_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic [KEY_MAX_W-1:0] sched_entry(
    input logic [SCHED_MAX_W-1:0] sched,
    input int                     k,
    input int                     key_w
  );
    logic [KEY_MAX_W-1:0] mask;
    mask = {KEY_MAX_W{1'b1}} >> (KEY_MAX_W - key_w);
    return KEY_MAX_W'(sched >> (k * key_w)) & mask;
  endfunction

endpackage

// File: rtl/cutelock_key_sched.sv
// Free-running key schedule counter and comparator; key_ok is true when the
// presented key word matches the schedule entry selected this cycle.
module cutelock_key_sched
  import cutelock_arb_pkg::*;
#(
  parameter int                          NUM_KEYS     = 4,
  parameter int                          KEY_W        = 3,
  parameter logic [NUM_KEYS*KEY_W-1:0]   KEY_SCHEDULE = {3'd5, 3'd2, 3'd7, 3'd1}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [KEY_W-1:0] keyinput,
  output logic             key_ok
);

  localparam int CNT_W = cnt_w(NUM_KEYS);

  logic [CNT_W-1:0] cnt;
  logic [KEY_W-1:0] expected_key;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(NUM_KEYS - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expected_key = KEY_W'(sched_entry(SCHED_MAX_W'(KEY_SCHEDULE), int'(cnt), KEY_W));
  assign key_ok       = (keyinput == expected_key);

endmodule

// File: rtl/cutelock_queue_arbiter.sv
// Arrival-order arbiter over N_REQ requesters; the sample/serve phase only
// advances on cycles where the key schedule check passes.
//   state     | meaning
//   PH_SAMPLE | capture REQUEST into ru, publish grant on GRANT_O
//   PH_SERVE  | release holder, enqueue one new requester, grant queue head
module cutelock_queue_arbiter
  import cutelock_arb_pkg::*;
#(
  parameter int                          N_REQ        = 4,
  parameter int                          NUM_KEYS     = 4,
  parameter int                          KEY_W        = 3,
  parameter logic [NUM_KEYS*KEY_W-1:0]   KEY_SCHEDULE = {3'd5, 3'd2, 3'd7, 3'd1}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] REQUEST,
  input  logic [KEY_W-1:0] keyinput,
  output logic [N_REQ-1:0] GRANT_O
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int OCC_W = occ_w(N_REQ);

  phase_e           phase;
  logic             key_ok;
  logic [N_REQ-1:0] ru;
  logic [N_REQ-1:0] fu;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] q [N_REQ];
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [OCC_W-1:0] count;

  logic [N_REQ-1:0] fu_n;
  logic [N_REQ-1:0] grant_n;
  logic [OCC_W-1:0] count_n;
  logic [IDX_W-1:0] g_idx;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] head_idx;
  logic             grant_free;
  logic             push;
  logic             pop;
  logic             avail;
  logic             do_grant;

  cutelock_key_sched #(
    .NUM_KEYS    (NUM_KEYS),
    .KEY_W       (KEY_W),
    .KEY_SCHEDULE(KEY_SCHEDULE)
  ) u_key_sched (
    .clock   (clock),
    .reset   (reset),
    .keyinput(keyinput),
    .key_ok  (key_ok)
  );

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(N_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [N_REQ-1:0] idx2oh(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (idx == IDX_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  always_comb begin
    fu_n       = fu;
    grant_n    = grant;
    grant_free = 1'b0;
    push       = 1'b0;
    push_idx   = '0;
    g_idx      = '0;

    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) g_idx = IDX_W'(i);
    end

    if ((grant != '0) && !ru[g_idx]) begin
      fu_n[g_idx] = 1'b0;
      grant_free  = 1'b1;
    end

    // Descending scan leaves the lowest eligible index selected.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (ru[i] && !fu_n[i]) begin
        push     = 1'b1;
        push_idx = IDX_W'(i);
      end
    end
    if (count == OCC_W'(N_REQ)) push = 1'b0;
    if (push) fu_n[push_idx] = 1'b1;

    avail    = (count != '0) || push;
    head_idx = (count == '0) ? push_idx : q[head];
    do_grant = (grant == '0) || grant_free;
    pop      = do_grant && avail;

    if (do_grant) grant_n = avail ? idx2oh(head_idx) : '0;

    count_n = count + OCC_W'(push) - OCC_W'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase   <= PH_SAMPLE;
      ru      <= '0;
      fu      <= '0;
      grant   <= '0;
      GRANT_O <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      for (int i = 0; i < N_REQ; i++) q[i] <= '0;
    end else begin
      if (key_ok) phase <= (phase == PH_SAMPLE) ? PH_SERVE : PH_SAMPLE;

      if (phase == PH_SAMPLE) begin
        ru      <= REQUEST;
        GRANT_O <= grant;
      end else begin
        fu    <= fu_n;
        grant <= grant_n;
        count <= count_n;
        if (push) begin
          q[tail] <= push_idx;
          tail    <= next_ptr(tail);
        end
        if (pop) head <= next_ptr(head);
      end
    end
  end

endmodule

// File: tb/tb_cutelock_queue_arbiter.sv
// Directed bench for the key-locked queue arbiter with hand-computed expectations.
module tb_cutelock_queue_arbiter;

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic [3:0] REQUEST  = 4'b0000;
  logic [2:0] keyinput = 3'd0;
  logic [3:0] GRANT_O;

  int   vectors     = 0;
  int   miscompares = 0;
  int   tcnt        = 0;
  bit   key_good    = 1'b1;
  logic tph         = 1'b0;

  localparam logic [2:0] KEYS [4] = '{3'd1, 3'd7, 3'd2, 3'd5};

  cutelock_queue_arbiter #(
    .N_REQ       (4),
    .NUM_KEYS    (4),
    .KEY_W       (3),
    .KEY_SCHEDULE({3'd5, 3'd2, 3'd7, 3'd1})
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .REQUEST (REQUEST),
    .keyinput(keyinput),
    .GRANT_O (GRANT_O)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    keyinput = key_good ? KEYS[tcnt] : 3'd0;
    @(posedge clock);
    #1;
    if (reset) begin
      tcnt = 0;
      tph  = 1'b0;
    end else begin
      tcnt = (tcnt + 1) % 4;
      if (key_good) tph = ~tph;
    end
  endtask

  task automatic chk_pair(input string tag, input logic [3:0] req,
                          input logic [3:0] go, input int cnt_exp);
    REQUEST = req;
    tick();
    tick();
    check({tag, "_grant_o"}, 8'(GRANT_O), 8'(go));
    check({tag, "_count"}, 8'(dut.count), 8'(cnt_exp));
    check({tag, "_phase"}, 8'(dut.phase), 8'(tph));
  endtask

  initial begin
    reset = 1'b1;
    tick();
    tick();
    check("rst_grant_o", 8'(GRANT_O), 8'h00);
    check("rst_count", 8'(dut.count), 8'h00);
    check("rst_phase", 8'(dut.phase), 8'h00);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      tick();
      check("idle_phase", 8'(dut.phase), 8'((i + 1) % 2));
      check("idle_grant_o", 8'(GRANT_O), 8'h00);
      check("idle_count", 8'(dut.count), 8'h00);
    end

    chk_pair("single_e1", 4'b0001, 4'b0000, 0);
    chk_pair("single_e2", 4'b0001, 4'b0001, 0);
    chk_pair("single_hold_a", 4'b0001, 4'b0001, 0);
    chk_pair("single_hold_b", 4'b0001, 4'b0001, 0);

    chk_pair("order_q2", 4'b0101, 4'b0001, 1);
    chk_pair("order_q1", 4'b0111, 4'b0001, 2);
    chk_pair("order_drop0", 4'b0110, 4'b0001, 1);
    chk_pair("order_drop2", 4'b0010, 4'b0100, 0);
    chk_pair("order_drop1", 4'b0000, 4'b0010, 0);
    chk_pair("order_idle", 4'b0000, 4'b0000, 0);

    chk_pair("all_bypass", 4'b1111, 4'b0000, 0);
    chk_pair("all_q1", 4'b1111, 4'b0001, 1);
    chk_pair("all_q2", 4'b1111, 4'b0001, 2);
    chk_pair("all_q3", 4'b1111, 4'b0001, 3);
    chk_pair("all_drop0", 4'b1110, 4'b0001, 2);
    chk_pair("all_hold1", 4'b1110, 4'b0010, 2);
    chk_pair("all_drop1", 4'b1100, 4'b0010, 1);
    chk_pair("all_drop2", 4'b1000, 4'b0100, 0);
    chk_pair("all_drop3", 4'b0000, 4'b1000, 0);
    chk_pair("all_idle", 4'b0000, 4'b0000, 0);

    reset   = 1'b1;
    REQUEST = 4'b0000;
    tick();
    reset    = 1'b0;
    key_good = 1'b0;
    REQUEST  = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("badkey_phase", 8'(dut.phase), 8'h00);
      check("badkey_grant_o", 8'(GRANT_O), 8'h00);
    end
    check("badkey_sched_pos", 8'(tcnt), 8'd2);
    key_good = 1'b1;
    chk_pair("rekey_e1", 4'b0001, 4'b0000, 0);
    chk_pair("rekey_e2", 4'b0001, 4'b0001, 0);

    chk_pair("deep_q1", 4'b0011, 4'b0001, 1);
    chk_pair("deep_q2", 4'b0111, 4'b0001, 2);
    chk_pair("deep_q3", 4'b1111, 4'b0001, 3);
    reset = 1'b1;
    tick();
    check("midrst_grant_o", 8'(GRANT_O), 8'h00);
    check("midrst_count", 8'(dut.count), 8'h00);
    check("midrst_grant", 8'(dut.grant), 8'h00);
    reset = 1'b0;
    chk_pair("post_rst_e1", 4'b1000, 4'b0000, 0);
    check("post_rst_grant", 8'(dut.grant), 8'b0000_1000);
    chk_pair("post_rst_e2", 4'b1000, 4'b1000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cutelock_queue_arbiter.md
# cutelock_queue_arbiter

Parametrised, logic-locked successor to our ITC99 b03 four-way FIFO-grant arbiter. It arbitrates N_REQ requesters in strict arrival order through an index queue. The sample/serve phase register is gated by a time-varying key check: a free-running schedule counter selects which key word must be present each cycle. The block sits in the Structural benchmark set as the scalable reference design for locking experiments.

## Interface
- N_REQ, 4, number of requesters (≥2); queue depth = N_REQ
- NUM_KEYS, 4, schedule length (≥2)
- KEY_W, 3, key word width
- KEY_SCHEDULE, {3'd5,3'd2,3'd7,3'd1}, packed NUM_KEYS×KEY_W; entry k = KEY_SCHEDULE[k*KEY_W +: KEY_W] (entry0=1, entry1=7, entry2=2, entry3=5)
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- REQUEST  in  N_REQ  request lines, bit i = requester i
- keyinput  in  KEY_W  key word, compared every cycle
- GRANT_O  out  N_REQ  registered one-hot (or zero) grant

## Operation
- Registers:
  - phase (SAMPLE=0, SERVE=1)
  - cnt (CNT_W = $clog2(NUM_KEYS))
  - ru[N_REQ] (sampled requests)
  - fu[N_REQ] (requester queued or granted)
  - queue[N_REQ] of IDX_W = $clog2(N_REQ) indices, with head/tail/count
  - grant[N_REQ]
  - GRANT_O
- Reset: every register cleared. phase=SAMPLE, cnt=0, queue empty, grant=0, GRANT_O=0.
- Schedule counter: cnt advances every cycle, wrapping NUM_KEYS-1→0, independent of key and phase.
- key_ok = (keyinput == entry[cnt]).
- Phase update:
  - key_ok: phase toggles.
  - !key_ok: phase holds.
- SAMPLE cycle:
  - ru ← REQUEST.
  - GRANT_O ← grant.
- SERVE cycle (evaluated in order, single edge):
  1. Release: if grant≠0 and ru[g]=0 for granted g, clear fu[g] and set grant_free.
  2. Enqueue: lowest index i with ru[i]&~fu[i] is pushed at the tail and fu[i] is set. At most one enqueue per SERVE.
  3. Grant: if grant==0 or grant_free:
     - grant ← one-hot of head (including an entry pushed this cycle when the queue was empty: bypass); head is popped.
     - If the queue is empty, grant ← 0.
- Push and pop in the same SERVE are legal; count is net-unchanged.
- fu guarantees each requester occupies at most one slot, so the queue never overflows. Overflow/underflow logic must still saturate and ignore pushes when full and pops when empty.
- Wrong key behaviour is deterministic:
  - Phase stuck in SAMPLE: grants freeze.
  - Phase stuck in SERVE: serves repeat on stale ru.
  - No X generation.
- Reset mid-operation overrides everything on that edge. A queue in flight is discarded.

## Timing
- With the correct key every cycle, phase alternates. Starting from reset, edges alternate SAMPLE, SERVE, SAMPLE…
- Request latency, empty queue: REQUEST high at SAMPLE edge E0 → grant at E1 → GRANT_O at E2.
- Release latency: holder drops REQUEST before SAMPLE edge → next requester's GRANT_O appears 2 edges later. GRANT_O is 0 between grants only if the queue is empty.
- A grant is held while its requester keeps REQUEST high; there is no timeout.
- REQUEST changes between SAMPLE edges are invisible.
- Counter and phase are unrelated after a wrong key. Correctness requires keyinput to track entry[cnt] on every cycle.

## Structure
- Package cutelock_arb_pkg:
  - phase_e enum
  - sched_entry(KEY_SCHEDULE, k) function
  - clog2-derived width localparams as functions of N_REQ/NUM_KEYS
- Sub-module cutelock_key_sched:
  - Contains cnt plus the comparator.
  - Ports: clock, reset, keyinput → key_ok.
  - Reusable across other locked benchmarks.
- Arbiter datapath (ru/fu/queue/grant) stays in the top level.

## Test plan
- Reset then 8 cycles correct key, REQUEST=0 → GRANT_O=0, queue count 0, phase alternating 0/1.
- Correct key, REQUEST=4'b0001 from E0 → GRANT_O=4'b0001 after E2, held while REQUEST[0]=1.
- REQUEST[2] then REQUEST[1] arrive on successive SAMPLE edges while 0 holds → drop 0: GRANT_O=4'b0100; drop 2: GRANT_O=4'b0010. Arrival order wins, not index order.
- REQUEST=4'b1111 together from empty → grants 0,1,2,3 in order as each releases. fu blocks re-queue of the current holder.
- keyinput=0 constant after reset → phase stays SAMPLE, GRANT_O=0 forever. Correct key restored on a cycle where cnt=2 (key 2) → normal operation resumes.
- Assert reset during a 3-deep queue → next edge GRANT_O=0, count 0. Subsequent REQUEST=4'b1000 granted after 2 SAMPLE/SERVE edges.
